// File: rtl/fp_wrb_arbiter_if.sv
// Completion-response handshakes from the four FP producers and the two
// register-file write ports driven by the write-back arbiter.
interface fp_wrb_arbiter_if #(
    parameter int unsigned REG_SIZE_WIDTH = 6,
    parameter int unsigned DATA_WIDTH     = 64
);
    logic                      falu1_rcu_resp_valid_i;
    logic                      falu1_rcu_resp_float_i;
    logic [REG_SIZE_WIDTH-1:0] falu1_wrb_address_i;
    logic [DATA_WIDTH-1:0]     falu1_wrb_data_i;
    logic                      falu1_wrb_ready_o;

    logic                      falu2_rcu_resp_valid_i;
    logic                      falu2_rcu_resp_float_i;
    logic [REG_SIZE_WIDTH-1:0] falu2_wrb_address_i;
    logic [DATA_WIDTH-1:0]     falu2_wrb_data_i;
    logic                      falu2_wrb_ready_o;

    logic                      lsu_rcu_resp_valid_i;
    logic                      lsu_rcu_resp_float_i;
    logic [REG_SIZE_WIDTH-1:0] lsu_wrb_address_i;
    logic [DATA_WIDTH-1:0]     lsu_wrb_data_i;
    logic                      lsu_wrb_ready_o;

    logic                      fdivsqrt_rcu_resp_valid_i;
    logic [REG_SIZE_WIDTH-1:0] fdivsqrt_wrb_address_i;
    logic [DATA_WIDTH-1:0]     fdivsqrt_wrb_data_i;
    logic                      fdivsqrt_wrb_ready_o;

    logic                      wr_first_valid;
    logic [REG_SIZE_WIDTH-1:0] wr_first_address;
    logic [DATA_WIDTH-1:0]     wr_first_data;
    logic                      wr_second_valid;
    logic [REG_SIZE_WIDTH-1:0] wr_second_address;
    logic [DATA_WIDTH-1:0]     wr_second_data;

    modport slave (
        input  falu1_rcu_resp_valid_i, falu1_rcu_resp_float_i, falu1_wrb_address_i,
               falu1_wrb_data_i,
        input  falu2_rcu_resp_valid_i, falu2_rcu_resp_float_i, falu2_wrb_address_i,
               falu2_wrb_data_i,
        input  lsu_rcu_resp_valid_i, lsu_rcu_resp_float_i, lsu_wrb_address_i, lsu_wrb_data_i,
        input  fdivsqrt_rcu_resp_valid_i, fdivsqrt_wrb_address_i, fdivsqrt_wrb_data_i,
        output falu1_wrb_ready_o, falu2_wrb_ready_o, lsu_wrb_ready_o, fdivsqrt_wrb_ready_o,
        output wr_first_valid, wr_first_address, wr_first_data,
        output wr_second_valid, wr_second_address, wr_second_data
    );

    modport master (
        output falu1_rcu_resp_valid_i, falu1_rcu_resp_float_i, falu1_wrb_address_i,
               falu1_wrb_data_i,
        output falu2_rcu_resp_valid_i, falu2_rcu_resp_float_i, falu2_wrb_address_i,
               falu2_wrb_data_i,
        output lsu_rcu_resp_valid_i, lsu_rcu_resp_float_i, lsu_wrb_address_i, lsu_wrb_data_i,
        output fdivsqrt_rcu_resp_valid_i, fdivsqrt_wrb_address_i, fdivsqrt_wrb_data_i,
        input  falu1_wrb_ready_o, falu2_wrb_ready_o, lsu_wrb_ready_o, fdivsqrt_wrb_ready_o,
        input  wr_first_valid, wr_first_address, wr_first_data,
        input  wr_second_valid, wr_second_address, wr_second_data
    );
endinterface

// File: rtl/fp_wrb_arbiter.sv
// FP write-back collector: per-source FIFOs feeding two regfile write ports through a
// round-robin arbiter that never issues two writes to one preg and drops writes to P0.
module fp_wrb_arbiter #(
    parameter int unsigned REG_SIZE_WIDTH = 6,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned FIFO_DEPTH     = 2
) (
    input logic            clk,
    input logic            rst,
    fp_wrb_arbiter_if.slave bus
);
    localparam int unsigned LW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = LW + 1;

    typedef logic [REG_SIZE_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

    logic [3:0] in_valid;
    addr_t      in_addr [4];
    data_t      in_data [4];

    assign in_valid[0] = bus.falu1_rcu_resp_valid_i & bus.falu1_rcu_resp_float_i;
    assign in_valid[1] = bus.falu2_rcu_resp_valid_i & bus.falu2_rcu_resp_float_i;
    assign in_valid[2] = bus.lsu_rcu_resp_valid_i & bus.lsu_rcu_resp_float_i;
    assign in_valid[3] = bus.fdivsqrt_rcu_resp_valid_i;
    assign in_addr[0]  = bus.falu1_wrb_address_i;
    assign in_addr[1]  = bus.falu2_wrb_address_i;
    assign in_addr[2]  = bus.lsu_wrb_address_i;
    assign in_addr[3]  = bus.fdivsqrt_wrb_address_i;
    assign in_data[0]  = bus.falu1_wrb_data_i;
    assign in_data[1]  = bus.falu2_wrb_data_i;
    assign in_data[2]  = bus.lsu_wrb_data_i;
    assign in_data[3]  = bus.fdivsqrt_wrb_data_i;

    logic [PW-1:0] rd_ptr_q [4];
    logic [PW-1:0] wr_ptr_q [4];
    addr_t         addr_mem [4][FIFO_DEPTH];
    data_t         data_mem [4][FIFO_DEPTH];

    logic [3:0] empty, full, ready, push, pop;
    addr_t      head_addr [4];
    data_t      head_data [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            empty[i]     = (rd_ptr_q[i] == wr_ptr_q[i]);
            // Same slot index with differing wrap bits means the FIFO is full.
            full[i]      = (rd_ptr_q[i][PW-1] != wr_ptr_q[i][PW-1]) &&
                           (rd_ptr_q[i][LW-1:0] == wr_ptr_q[i][LW-1:0]);
            ready[i]     = !full[i] && !rst;
            push[i]      = in_valid[i] && ready[i];
            head_addr[i] = addr_mem[i][rd_ptr_q[i][LW-1:0]];
            head_data[i] = data_mem[i][rd_ptr_q[i][LW-1:0]];
        end
    end

    assign bus.falu1_wrb_ready_o    = ready[0];
    assign bus.falu2_wrb_ready_o    = ready[1];
    assign bus.lsu_wrb_ready_o      = ready[2];
    assign bus.fdivsqrt_wrb_ready_o = ready[3];

    logic [1:0] rr_q, rr_d, idx, g0_idx, g1_idx;
    logic       g0_v, g1_v;

    always_comb begin
        g0_v   = 1'b0;
        g1_v   = 1'b0;
        g0_idx = 2'd0;
        g1_idx = 2'd0;
        idx    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!empty[idx] && head_addr[idx] != '0) begin
                if (!g0_v) begin
                    g0_v   = 1'b1;
                    g0_idx = idx;
                end else if (!g1_v && head_addr[idx] != head_addr[g0_idx]) begin
                    g1_v   = 1'b1;
                    g1_idx = idx;
                end
            end
        end

        if (g1_v) begin
            rr_d = g1_idx + 2'd1;
        end else if (g0_v) begin
            rr_d = g0_idx + 2'd1;
        end else begin
            rr_d = rr_q;
        end

        // P0 heads are discarded alongside whatever was granted.
        for (int i = 0; i < 4; i++) begin
            pop[i] = !empty[i] && ((head_addr[i] == '0) ||
                                   (g0_v && g0_idx == 2'(i)) ||
                                   (g1_v && g1_idx == 2'(i)));
        end
    end

    logic  wr_first_valid_q, wr_second_valid_q;
    addr_t wr_first_address_q, wr_second_address_q;
    data_t wr_first_data_q, wr_second_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q                <= 2'd0;
            wr_first_valid_q    <= 1'b0;
            wr_first_address_q  <= '0;
            wr_first_data_q     <= '0;
            wr_second_valid_q   <= 1'b0;
            wr_second_address_q <= '0;
            wr_second_data_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            rr_q                <= rr_d;
            wr_first_valid_q    <= g0_v;
            wr_first_address_q  <= g0_v ? head_addr[g0_idx] : '0;
            wr_first_data_q     <= g0_v ? head_data[g0_idx] : '0;
            wr_second_valid_q   <= g1_v;
            wr_second_address_q <= g1_v ? head_addr[g1_idx] : '0;
            wr_second_data_q    <= g1_v ? head_data[g1_idx] : '0;
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            end
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                addr_mem[i][wr_ptr_q[i][LW-1:0]] <= in_addr[i];
                data_mem[i][wr_ptr_q[i][LW-1:0]] <= in_data[i];
            end
        end
    end

    assign bus.wr_first_valid    = wr_first_valid_q;
    assign bus.wr_first_address  = wr_first_address_q;
    assign bus.wr_first_data     = wr_first_data_q;
    assign bus.wr_second_valid   = wr_second_valid_q;
    assign bus.wr_second_address = wr_second_address_q;
    assign bus.wr_second_data    = wr_second_data_q;
endmodule

// File: tb/tb_fp_wrb_arbiter.sv
// Bench for fp_wrb_arbiter: directed scenarios plus random traffic checked every cycle
// against a queue-based model of the collector.
module tb_fp_wrb_arbiter;
    localparam int AW    = 6;
    localparam int DW    = 64;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]    v, f;
    logic [AW-1:0] a [4];
    logic [DW-1:0] d [4];

    fp_wrb_arbiter_if #(.REG_SIZE_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    fp_wrb_arbiter #(.REG_SIZE_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.falu1_rcu_resp_valid_i    = v[0];
    assign bus.falu1_rcu_resp_float_i    = f[0];
    assign bus.falu1_wrb_address_i       = a[0];
    assign bus.falu1_wrb_data_i          = d[0];
    assign bus.falu2_rcu_resp_valid_i    = v[1];
    assign bus.falu2_rcu_resp_float_i    = f[1];
    assign bus.falu2_wrb_address_i       = a[1];
    assign bus.falu2_wrb_data_i          = d[1];
    assign bus.lsu_rcu_resp_valid_i      = v[2];
    assign bus.lsu_rcu_resp_float_i      = f[2];
    assign bus.lsu_wrb_address_i         = a[2];
    assign bus.lsu_wrb_data_i            = d[2];
    assign bus.fdivsqrt_rcu_resp_valid_i = v[3];
    assign bus.fdivsqrt_wrb_address_i    = a[3];
    assign bus.fdivsqrt_wrb_data_i       = d[3];

    wire [3:0] readys = {bus.fdivsqrt_wrb_ready_o, bus.lsu_wrb_ready_o,
                         bus.falu2_wrb_ready_o, bus.falu1_wrb_ready_o};

    // Reference model: queue contents per source and the round-robin start point.
    ent_t          mq [4][$];
    int            rr_m;
    logic          e1v, e2v;
    logic [AW-1:0] e1a, e2a;
    logic [DW-1:0] e1d, e2d;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: predict from the pre-edge model state, advance, then compare.
    task automatic step();
        bit   acc [4];
        ent_t pend [4];
        int   g0 = -1;
        int   g1 = -1;
        logic [3:0] er;
        for (int i = 0; i < 4; i++) begin
            acc[i]  = !rst && v[i] && (i == 3 || f[i]) && mq[i].size() < DEPTH;
            pend[i] = '{a: a[i], d: d[i]};
        end
        for (int k = 0; k < 4; k++) begin
            int i = (rr_m + k) % 4;
            if (mq[i].size() != 0 && mq[i][0].a != '0) begin
                if (g0 < 0) g0 = i;
                else if (g1 < 0 && mq[i][0].a != mq[g0][0].a) g1 = i;
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            rr_m = 0;
            e1v = 0; e1a = '0; e1d = '0;
            e2v = 0; e2a = '0; e2d = '0;
        end else begin
            e1v = (g0 >= 0);
            e1a = (g0 >= 0) ? mq[g0][0].a : '0;
            e1d = (g0 >= 0) ? mq[g0][0].d : '0;
            e2v = (g1 >= 0);
            e2a = (g1 >= 0) ? mq[g1][0].a : '0;
            e2d = (g1 >= 0) ? mq[g1][0].d : '0;
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && (mq[i][0].a == '0 || i == g0 || i == g1))
                    void'(mq[i].pop_front());
            end
            for (int i = 0; i < 4; i++) if (acc[i]) mq[i].push_back(pend[i]);
            if (g1 >= 0) rr_m = (g1 + 1) % 4;
            else if (g0 >= 0) rr_m = (g0 + 1) % 4;
        end
        for (int i = 0; i < 4; i++) er[i] = !rst && mq[i].size() < DEPTH;
        chk("wr_first", {bus.wr_first_valid, bus.wr_first_address, bus.wr_first_data},
            {e1v, e1a, e1d});
        chk("wr_second", {bus.wr_second_valid, bus.wr_second_address, bus.wr_second_data},
            {e2v, e2a, e2d});
        chk("ready", readys, er);
    endtask

    task automatic idle_inputs();
        v = '0;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            d[i] = '0;
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        idle_inputs();
        rr_m = 0;

        // Reset held with every source presenting a float response.
        v = 4'hF;
        f = 4'hF;
        for (int i = 0; i < 4; i++) a[i] = AW'(i + 10);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("reset_ready", readys, 4'h0);
            chk("reset_wr", {bus.wr_first_valid, bus.wr_first_address,
                             bus.wr_second_valid, bus.wr_second_address}, '0);
        end
        idle_inputs();
        rst = 1'b0;
        step();
        chk("release_ready", readys, 4'hF);

        // Single write from falu1.
        v[0] = 1'b1; f[0] = 1'b1; a[0] = 6'd5; d[0] = 64'hDEAD_BEEF;
        step();
        idle_inputs();
        step();
        chk("single_first", {bus.wr_first_valid, bus.wr_first_address, bus.wr_first_data},
            {1'b1, 6'd5, 64'hDEAD_BEEF});
        chk("single_second", bus.wr_second_valid, 1'b0);
        step();

        // Four-way burst from rr_ptr = 0.
        reset_pulse();
        v = 4'hF;
        f = 4'hF;
        for (int i = 0; i < 4; i++) begin
            a[i] = AW'(i + 1);
            d[i] = 64'(100 + i);
        end
        step();
        idle_inputs();
        step();
        chk("burst_a", {bus.wr_first_address, bus.wr_second_address}, {6'd1, 6'd2});
        step();
        chk("burst_a1", {bus.wr_first_address, bus.wr_second_address}, {6'd3, 6'd4});

        // Collision on preg 7 between falu1 and lsu; rr_ptr is back at 0.
        v = 4'b0101; f = 4'b0101;
        a[0] = 6'd7; d[0] = 64'h11;
        a[2] = 6'd7; d[2] = 64'h33;
        step();
        idle_inputs();
        step();
        chk("coll_a", {bus.wr_first_valid, bus.wr_first_address, bus.wr_first_data,
                       bus.wr_second_valid}, {1'b1, 6'd7, 64'h11, 1'b0});
        step();
        chk("coll_a1", {bus.wr_first_valid, bus.wr_first_address, bus.wr_first_data},
            {1'b1, 6'd7, 64'h33});

        // Filtering: falu2 to P0, lsu integer response.
        v = 4'b0110; f = 4'b0010;
        a[1] = 6'd0; d[1] = 64'h22;
        a[2] = 6'd9; d[2] = 64'h44;
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            chk("filter_none", {bus.wr_first_valid, bus.wr_second_valid}, 2'b00);
        end

        // Backpressure: every source valid each cycle with random nonzero pregs.
        v = 4'hF;
        f = 4'hF;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i] = AW'($urandom_range(1, 63));
                d[i] = {$urandom, $urandom};
            end
            step();
        end

        // Random traffic with P0, integer responses, collisions and a mid-stream reset.
        for (int c = 0; c < 300; c++) begin
            rst = (c >= 150 && c < 152);
            for (int i = 0; i < 4; i++) begin
                v[i] = 1'($urandom_range(0, 1));
                f[i] = ($urandom_range(0, 3) != 0);
                a[i] = AW'($urandom_range(0, 7));
                d[i] = {$urandom, $urandom};
            end
            step();
        end
        rst = 1'b0;

        // Drain.
        idle_inputs();
        for (int c = 0; c < 8; c++) step();
        chk("drain_ready", readys, 4'hF);
        chk("drain_idle", {bus.wr_first_valid, bus.wr_second_valid}, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
